dispense_ctrl: RTL and testbench

//  Downstream stage of the coin-credit vending FSM. Consumes its 2-bit drop code (00/01/10 = 0/1/2 items)
//  and turns each drop event into 4-phase req/ack handshakes with the dispenser mechanism.

---
 rtl/dispense_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dispense_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_ctrl.sv
// dispense_ctrl
//   Downstream stage of the coin-credit vending FSM. Converts drop events into
//   4-phase req/ack handshakes with the dispenser mechanism. It also tracks the
//   on-hand inventory, the queue of accepted items and the count of refused items.
//   Optional ack watchdog and JAM state: define DISPENSE_TIMEOUT_EN.
module dispense_ctrl #(
    parameter int unsigned INV_W    = 6,
    parameter int unsigned INV_INIT = 16,
    parameter int unsigned PEND_MAX = 7,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic [1:0]       drop,
    input  logic             restock,
    input  logic [INV_W-1:0] restock_qty,
    input  logic             disp_ack,
    output logic             disp_req,
    output logic [2:0]       pending,
    output logic [INV_W-1:0] inventory,
    output logic             sold_out,
    output logic [3:0]       refund_cnt,
    output logic             busy,
    output logic             jam
);

    // One extra bit so that inventory arithmetic can detect saturation.
    localparam int unsigned   CW      = INV_W + 1;
    localparam logic [CW-1:0] INV_SAT = {1'b0, {INV_W{1'b1}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;
`ifdef DISPENSE_TIMEOUT_EN
    localparam logic [1:0] S_JAM      = 2'd3;
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT);
`endif

    logic [1:0]       drop_q,   drop_d;
    logic [1:0]       state_q,  state_d;
    logic [2:0]       pend_q,   pend_d;
    logic [INV_W-1:0] inv_q,    inv_d;
    logic [3:0]       refund_q, refund_d;
`ifdef DISPENSE_TIMEOUT_EN
    logic [7:0]       wdog_q,   wdog_d;
    logic [7:0]       wdog_inc;
    logic             trip;
`endif

    logic             drop_evt;
    logic [1:0]       drop_n;
    logic [CW-1:0]    inv_ext;
    logic [CW-1:0]    pend_ext;
    logic [CW-1:0]    free_stock;
    logic [CW-1:0]    free_queue;
    logic [CW-1:0]    free_slots;
    logic [1:0]       acc_n;
    logic [1:0]       rej_n;
    logic             dec;
    logic [4:0]       ref_add;
    logic [4:0]       ref_sum;
    logic [CW-1:0]    inv_sum;

    // Drop history: only a 00 -> 01/10 transition counts as a new event.
    always_comb begin
        drop_d = drop;
    end

    // Event detection and acceptance against free stock and free queue slots.
    always_comb begin
        drop_evt   = ((drop == 2'b01) || (drop == 2'b10)) && (drop_q == 2'b00);
        drop_n     = drop_evt ? drop : 2'b00;
        inv_ext    = {1'b0, inv_q};
        pend_ext   = CW'(pend_q);
        free_stock = inv_ext - pend_ext;
        free_queue = CW'(PEND_MAX) - pend_ext;
        free_slots = (free_stock < free_queue) ? free_stock : free_queue;
`ifdef DISPENSE_TIMEOUT_EN
        if (state_q == S_JAM) begin
            free_slots = '0;
        end
`endif
        acc_n = (CW'(drop_n) < free_slots) ? drop_n : 2'(free_slots);
        rej_n = drop_n - acc_n;
    end

`ifdef DISPENSE_TIMEOUT_EN
    assign wdog_inc = wdog_q + 8'd1;
`endif

    // Handshake sequencer; the item is consumed in the cycle ack is seen in REQ.
    always_comb begin
        state_d = state_q;
        dec     = 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
        wdog_d  = wdog_q;
        trip    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pend_q != 3'd0) begin
                    state_d = S_REQ;
`ifdef DISPENSE_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            S_REQ: begin
                if (disp_ack) begin
                    state_d = S_REL;
                    dec     = 1'b1;
`ifdef DISPENSE_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end else begin
`ifdef DISPENSE_TIMEOUT_EN
                    wdog_d = wdog_inc;
                    if (wdog_inc == WDOG_LIMIT) begin
                        state_d = S_JAM;
                        trip    = 1'b1;
                    end
`endif
                end
            end
            S_REL: begin
                if (!disp_ack) begin
                    state_d = S_IDLE;
                end else begin
`ifdef DISPENSE_TIMEOUT_EN
                    wdog_d = wdog_inc;
                    if (wdog_inc == WDOG_LIMIT) begin
                        state_d = S_JAM;
                        trip    = 1'b1;
                    end
`endif
                end
            end
            default: begin
`ifdef DISPENSE_TIMEOUT_EN
                // JAM is left only through reset.
                state_d = S_JAM;
`else
                state_d = S_IDLE;
`endif
            end
        endcase
    end

    // Counter updates: accept, refund, dispense and restock all land in one cycle.
    always_comb begin
        pend_d  = pend_q + {1'b0, acc_n} - {2'b00, dec};
        ref_add = 5'(rej_n);
`ifdef DISPENSE_TIMEOUT_EN
        // Queued items and anything arriving in the trip cycle are all refunded.
        if (trip) begin
            pend_d  = '0;
            ref_add = 5'(pend_q) + 5'(drop_n);
        end
`endif
        ref_sum  = {1'b0, refund_q} + ref_add;
        refund_d = (ref_sum > 5'd15) ? 4'hF : ref_sum[3:0];

        inv_sum = inv_ext - CW'(dec) + (restock ? {1'b0, restock_qty} : '0);
        inv_d   = (inv_sum > INV_SAT) ? {INV_W{1'b1}} : inv_sum[INV_W-1:0];
    end

    // State registers; reset abandons any handshake in flight.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            drop_q   <= 2'b00;
            state_q  <= S_IDLE;
            pend_q   <= '0;
            inv_q    <= INV_W'(INV_INIT);
            refund_q <= '0;
        end else begin
            drop_q   <= drop_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            inv_q    <= inv_d;
            refund_q <= refund_d;
        end
    end

`ifdef DISPENSE_TIMEOUT_EN
    // Watchdog counter for the time spent waiting in REQ or REL.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign disp_req   = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE);
    assign pending    = pend_q;
    assign inventory  = inv_q;
    assign refund_cnt = refund_q;
    assign sold_out   = (inv_ext == pend_ext);
`ifdef DISPENSE_TIMEOUT_EN
    assign jam        = (state_q == S_JAM);
`else
    assign jam        = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_ctrl.sv
// tb_dispense_ctrl
//   Directed bench for dispense_ctrl. This bench keeps a counter-level model
//   that is checked every cycle, and adds hand-computed expectations per scenario.
module tb_dispense_ctrl;

    logic       clock;
    logic       reset_L;
    logic [1:0] drop;
    logic       restock;
    logic [5:0] restock_qty;
    logic       disp_ack;
    logic       disp_req;
    logic [2:0] pending;
    logic [5:0] inventory;
    logic       sold_out;
    logic [3:0] refund_cnt;
    logic       busy;
    logic       jam;

    int n_chk = 0;
    int n_err = 0;

    logic check_en;
    logic ack_auto;
    logic ack_manual;
    int   ack_cnt;
    int   hs_cnt = 0;
    logic req_prev = 1'b0;

    // Model state: plain counters plus "request outstanding" / "waiting for ack to fall".
    int         m_inv;
    int         m_pend;
    int         m_ref;
    logic       m_req;
    logic       m_wait;
    logic [1:0] m_dprev;

    dispense_ctrl #(
        .INV_W   (6),
        .INV_INIT(16),
        .PEND_MAX(7),
        .TIMEOUT (255)
    ) dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .drop       (drop),
        .restock    (restock),
        .restock_qty(restock_qty),
        .disp_ack   (disp_ack),
        .disp_req   (disp_req),
        .pending    (pending),
        .inventory  (inventory),
        .sold_out   (sold_out),
        .refund_cnt (refund_cnt),
        .busy       (busy),
        .jam        (jam)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Behavioural model updated on the same edges as the DUT.
    always @(posedge clock or negedge reset_L) begin : model
        int n, fr, acc, dec, inv_n, ref_n;
        if (!reset_L) begin
            m_inv   <= 16;
            m_pend  <= 0;
            m_ref   <= 0;
            m_req   <= 1'b0;
            m_wait  <= 1'b0;
            m_dprev <= 2'b00;
        end else begin
            n     = (((drop == 2'd1) || (drop == 2'd2)) && (m_dprev == 2'd0)) ? int'(drop) : 0;
            dec   = (m_req && disp_ack) ? 1 : 0;
            fr    = ((m_inv - m_pend) < (7 - m_pend)) ? (m_inv - m_pend) : (7 - m_pend);
            acc   = (n < fr) ? n : fr;
            ref_n = m_ref + n - acc;
            m_ref  <= (ref_n > 15) ? 15 : ref_n;
            m_pend <= m_pend + acc - dec;
            inv_n = m_inv - dec + (restock ? int'(restock_qty) : 0);
            m_inv  <= (inv_n > 63) ? 63 : inv_n;
            if (m_req) begin
                if (disp_ack) begin
                    m_req  <= 1'b0;
                    m_wait <= 1'b1;
                end
            end else if (m_wait) begin
                if (!disp_ack) m_wait <= 1'b0;
            end else if (m_pend > 0) begin
                m_req <= 1'b1;
            end
            m_dprev <= drop;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (check_en) begin
            chk("cyc_disp_req",   32'(disp_req),   int'(m_req));
            chk("cyc_pending",    32'(pending),    m_pend);
            chk("cyc_inventory",  32'(inventory),  m_inv);
            chk("cyc_refund_cnt", 32'(refund_cnt), m_ref);
            chk("cyc_busy",       32'(busy),       int'(m_req || m_wait));
            chk("cyc_sold_out",   32'(sold_out),   int'(m_inv == m_pend));
            chk("cyc_jam",        32'(jam),        0);
        end
    end

    // Handshake counter (rising edges of disp_req).
    always @(negedge clock) begin
        if (disp_req && !req_prev) hs_cnt++;
        req_prev = disp_req;
    end

    // Dispenser responder: raises ack 2 cycles after req, drops it once req falls.
    initial begin
        disp_ack = 1'b0;
        ack_cnt  = 0;
        forever begin
            @(negedge clock);
            #1;
            if (!ack_auto) begin
                disp_ack = ack_manual;
                ack_cnt  = 0;
            end else if (disp_req && !disp_ack) begin
                ack_cnt++;
                if (ack_cnt >= 2) begin
                    disp_ack = 1'b1;
                    ack_cnt  = 0;
                end
            end else if (!disp_req) begin
                disp_ack = 1'b0;
                ack_cnt  = 0;
            end
        end
    end

    task automatic do_reset();
        reset_L = 1'b0;
        tick(2);
        reset_L = 1'b1;
        tick(1);
    endtask

    task automatic drop_evt(input logic [1:0] code);
        drop = code;
        tick(1);
        drop = 2'b00;
        tick(1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            if (!busy && pending == 3'd0) break;
            tick(1);
        end
        if (i == max_cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_idle: got busy=%0d pending=%0d expected idle within %0d cycles",
                     busy, pending, max_cyc);
        end
    endtask

    initial begin : stim
        int base;
        reset_L     = 1'b0;
        drop        = 2'b00;
        restock     = 1'b0;
        restock_qty = '0;
        ack_auto    = 1'b1;
        ack_manual  = 1'b0;
        check_en    = 1'b1;
        tick(3);
        reset_L = 1'b1;

        // Reset state
        chk("rst_inventory", 32'(inventory), 16);
        chk("rst_pending",   32'(pending),   0);
        chk("rst_refund",    32'(refund_cnt), 0);
        chk("rst_disp_req",  32'(disp_req),  0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_sold_out",  32'(sold_out),  0);

        // T1 single drop, latency of two clocks
        drop = 2'b01;
        tick(1);
        chk("t1_pend_after_evt", 32'(pending), 1);
        chk("t1_req_1clk",       32'(disp_req), 0);
        drop = 2'b00;
        tick(1);
        chk("t1_req_2clk",       32'(disp_req), 1);
        wait_idle(50);
        chk("t1_inventory", 32'(inventory), 15);
        chk("t1_pending",   32'(pending),   0);
        chk("t1_refund",    32'(refund_cnt), 0);
        chk("t1_model_inv", 32'(m_inv),     15);

        // T2 double drop held for several cycles
        do_reset();
        base = hs_cnt;
        drop = 2'b10;
        tick(6);
        drop = 2'b00;
        wait_idle(100);
        chk("t2_handshakes", 32'(hs_cnt - base), 2);
        chk("t2_inventory",  32'(inventory), 14);
        chk("t2_busy",       32'(busy), 0);

        // T3 stock-out: run inventory down to 1, then ask for two
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drop_evt(2'b10);
            wait_idle(100);
        end
        drop_evt(2'b01);
        wait_idle(100);
        chk("t3_inv_one", 32'(inventory), 1);
        base = hs_cnt;
        drop_evt(2'b10);
        chk("t3_refund_evt", 32'(refund_cnt), 1);
        wait_idle(100);
        chk("t3_handshakes", 32'(hs_cnt - base), 1);
        chk("t3_inventory",  32'(inventory), 0);
        chk("t3_sold_out",   32'(sold_out), 1);
        drop_evt(2'b10);
        chk("t3_refund_empty", 32'(refund_cnt), 3);
        chk("t3_pend_empty",   32'(pending), 0);

        // T4 queue full with ack withheld, then refund saturation
        do_reset();
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        repeat (5) drop_evt(2'b10);
        chk("t4_pending",  32'(pending), 7);
        chk("t4_refund",   32'(refund_cnt), 3);
        chk("t4_disp_req", 32'(disp_req), 1);
        chk("t4_model_ref", 32'(m_ref), 3);
        repeat (7) drop_evt(2'b10);
        chk("t4_refund_sat", 32'(refund_cnt), 15);
        ack_auto = 1'b1;
        wait_idle(200);
        chk("t4_inventory", 32'(inventory), 9);
        chk("t4_refund_end", 32'(refund_cnt), 15);

        // T5 event + restock in the ack cycle of a REQ with pending=1
        do_reset();
        repeat (3) begin
            drop_evt(2'b10);
            wait_idle(100);
        end
        chk("t5_inv_ten", 32'(inventory), 10);
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        drop_evt(2'b01);
        for (int k = 0; k < 10 && !disp_req; k++) tick(1);
        chk("t5_req_up", 32'(disp_req), 1);
        ack_manual  = 1'b1;
        drop        = 2'b01;
        restock     = 1'b1;
        restock_qty = 6'd4;
        tick(1);
        chk("t5_pending",   32'(pending), 1);
        chk("t5_inventory", 32'(inventory), 13);
        chk("t5_refund",    32'(refund_cnt), 0);
        drop        = 2'b00;
        restock     = 1'b0;
        restock_qty = '0;
        ack_manual  = 1'b0;
        ack_auto    = 1'b1;
        wait_idle(100);
        chk("t5_inv_end", 32'(inventory), 12);

        // Restock saturation and drop code decoding (hold, 01->10, 11)
        do_reset();
        restock     = 1'b1;
        restock_qty = 6'd63;
        tick(1);
        restock     = 1'b0;
        restock_qty = '0;
        chk("sat_inventory", 32'(inventory), 63);
        base = hs_cnt;
        drop = 2'b01;
        tick(1);
        drop = 2'b10;
        tick(1);
        drop = 2'b11;
        tick(1);
        drop = 2'b00;
        tick(1);
        wait_idle(100);
        chk("code_handshakes", 32'(hs_cnt - base), 1);
        chk("code_inventory",  32'(inventory), 62);
        drop = 2'b11;
        tick(1);
        drop = 2'b00;
        tick(1);
        chk("illegal_pending", 32'(pending), 0);
        chk("illegal_busy",    32'(busy), 0);

        // Asynchronous reset in the middle of a handshake
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        drop_evt(2'b01);
        #2;
        reset_L = 1'b0;
        #1;
        chk("arst_disp_req",  32'(disp_req), 0);
        chk("arst_pending",   32'(pending), 0);
        chk("arst_inventory", 32'(inventory), 16);
        chk("arst_busy",      32'(busy), 0);
        tick(1);
        reset_L  = 1'b1;
        ack_auto = 1'b1;
        tick(2);

`ifdef DISPENSE_TIMEOUT_EN
        // T6 watchdog: three queued items, ack never arrives
        check_en   = 1'b0;
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        drop_evt(2'b10);
        drop_evt(2'b01);
        chk("t6_pending", 32'(pending), 3);
        begin
            int k;
            for (k = 0; k < 400 && !jam; k++) tick(1);
        end
        chk("t6_jam",      32'(jam), 1);
        chk("t6_pend",     32'(pending), 0);
        chk("t6_refund",   32'(refund_cnt), 3);
        chk("t6_disp_req", 32'(disp_req), 0);
        chk("t6_inv",      32'(inventory), 16);
        drop_evt(2'b01);
        chk("t6_jam_refund", 32'(refund_cnt), 4);
        #2;
        reset_L = 1'b0;
        #1;
        chk("t6_rst_jam",    32'(jam), 0);
        chk("t6_rst_refund", 32'(refund_cnt), 0);
        chk("t6_rst_inv",    32'(inventory), 16);
        tick(1);
        reset_L  = 1'b1;
        ack_auto = 1'b1;
        tick(1);
        check_en = 1'b1;
        tick(2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
